gbe_txmac: RTL and testbench

Gigabit Ethernet transmit MAC framer. It sits directly downstream of the transmit packet buffer on `mac_clk`, and accepts packets over the `mac_txd`/`mac_txdv`/`mac_txack` byte handshake. For each packet it drives a complete GMII frame: preamble, SFD, payload, optional minimum-size padding, CRC-32 FCS and inter-frame gap.

---
 rtl/gbe_pkg.sv | 20 ++
 rtl/gbe_crc32_d8.sv | 17 +
 rtl/gbe_txmac.sv | 172 +++++++++++++++++
 tb/tb_gbe_txmac.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_pkg.sv
// Shared constants and state enumeration for the gigabit Ethernet transmit MAC.
package gbe_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
    localparam logic [7:0]  SFD_BYTE           = 8'hD5;
    localparam logic [31:0] CRC_INIT           = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE        = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY_REFLECTED = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

endpackage

// File: rtl/gbe_crc32_d8.sv
// Combinational byte-wide IEEE 802.3 CRC-32 step (reflected form, LSB first).
module gbe_crc32_d8
    import gbe_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFLECTED) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/gbe_txmac.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS and inter-frame gap.
// Define GBE_TXMAC_PAD_EN to zero-pad short payloads up to MIN_DATA_BYTES.
module gbe_txmac
    import gbe_pkg::*;
#(
    parameter int IFG_BYTES      = 12,
    parameter int PREAMBLE_BYTES = 7
`ifdef GBE_TXMAC_PAD_EN
    ,
    parameter int MIN_DATA_BYTES = 60
`endif
) (
    input  logic       mac_clk,
    input  logic       reset,
    input  logic [7:0] mac_txd,
    input  logic       mac_txdv,
    output logic       mac_txack,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_sent
);

    localparam logic [10:0] IFG_LOAD  = 11'(IFG_BYTES);
    localparam logic [10:0] IFG_REARM = 11'(IFG_BYTES - 1);
    localparam logic [10:0] PRE_LOAD  = 11'(PREAMBLE_BYTES);

    tx_state_t   state, state_nx;
    logic [10:0] cnt, cnt_nx;
    logic [31:0] crc, crc_nx, crc_step, fcs_word;
    logic [7:0]  crc_byte;
    logic [7:0]  txd_nx;
    logic        tx_en_nx, txack_nx, sent_nx;

`ifdef GBE_TXMAC_PAD_EN
    localparam logic [10:0] MIN_COUNT = 11'(MIN_DATA_BYTES);
    logic pad_short;
    assign pad_short = (cnt < MIN_COUNT);
`endif

    assign gmii_tx_er = 1'b0;
    assign fcs_word   = ~crc;

    // Byte entering the CRC this cycle: the sampled payload byte, otherwise zero padding.
    assign crc_byte = ((state == ST_SFD || state == ST_DATA) && mac_txdv) ? mac_txd : 8'h00;

    gbe_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_step)
    );

    always_ff @(posedge mac_clk) begin
        if (reset) begin
            state      <= ST_IFG;
            cnt        <= IFG_LOAD;
            crc        <= CRC_INIT;
            mac_txack  <= 1'b0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            frame_sent <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            crc        <= crc_nx;
            mac_txack  <= txack_nx;
            gmii_txd   <= txd_nx;
            gmii_tx_en <= tx_en_nx;
            frame_sent <= sent_nx;
        end
    end

    // Outputs are registered: each branch decides what goes on GMII in the next cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        crc_nx   = crc;
        txd_nx   = 8'h00;
        tx_en_nx = 1'b0;
        txack_nx = 1'b0;
        sent_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mac_txdv) begin
                    state_nx = ST_PREAMBLE;
                    cnt_nx   = PRE_LOAD;
                    txd_nx   = PREAMBLE_BYTE;
                    tx_en_nx = 1'b1;
                end
            end

            ST_PREAMBLE: begin
                tx_en_nx = 1'b1;
                if (cnt == 11'd1) begin
                    state_nx = ST_SFD;
                    cnt_nx   = 11'd0;
                    crc_nx   = CRC_INIT;
                    txd_nx   = SFD_BYTE;
                    txack_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 11'd1;
                    txd_nx = PREAMBLE_BYTE;
                end
            end

            // SFD shares the payload path so a low mac_txdv in the ack cycle yields an empty payload.
            ST_SFD, ST_DATA: begin
                tx_en_nx = 1'b1;
                if (mac_txdv) begin
                    state_nx = ST_DATA;
                    txd_nx   = mac_txd;
                    crc_nx   = crc_step;
                    cnt_nx   = cnt + 11'd1;
`ifdef GBE_TXMAC_PAD_EN
                end else if (pad_short) begin
                    state_nx = ST_PAD;
                    txd_nx   = 8'h00;
                    crc_nx   = crc_step;
                    cnt_nx   = cnt + 11'd1;
`endif
                end else begin
                    state_nx = ST_FCS;
                    txd_nx   = fcs_word[7:0];
                    cnt_nx   = 11'd1;
                end
            end

`ifdef GBE_TXMAC_PAD_EN
            ST_PAD: begin
                tx_en_nx = 1'b1;
                if (pad_short) begin
                    txd_nx = 8'h00;
                    crc_nx = crc_step;
                    cnt_nx = cnt + 11'd1;
                end else begin
                    state_nx = ST_FCS;
                    txd_nx   = fcs_word[7:0];
                    cnt_nx   = 11'd1;
                end
            end
`endif

            ST_FCS: begin
                if (cnt == 11'd4) begin
                    state_nx = ST_IFG;
                    cnt_nx   = IFG_REARM;
                    sent_nx  = 1'b1;
                end else begin
                    tx_en_nx = 1'b1;
                    txd_nx   = fcs_word[{cnt[1:0], 3'b000} +: 8];
                    cnt_nx   = cnt + 11'd1;
                end
            end

            // The IDLE sampling cycle completes the gap, hence the rearm value one short.
            ST_IFG: begin
                if (cnt <= 11'd1) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 11'd1;
                end
            end

            default: begin
                state_nx = ST_IFG;
                cnt_nx   = IFG_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_gbe_txmac.sv
// Scoreboard bench for gbe_txmac: frame-level reference model, randomized payloads.
module tb_gbe_txmac;
    import gbe_pkg::*;

    localparam int IFG     = 12;
    localparam int MIN_LEN = 60;
`ifdef GBE_TXMAC_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       mac_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mac_txd = 8'h00;
    logic       mac_txdv = 1'b0;
    logic       mac_txack;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       frame_sent;

    gbe_txmac dut (
        .mac_clk    (mac_clk),
        .reset      (reset),
        .mac_txd    (mac_txd),
        .mac_txdv   (mac_txdv),
        .mac_txack  (mac_txack),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .frame_sent (frame_sent)
    );

    always #5 mac_clk = ~mac_clk;

    int cyc = 0;
    always @(posedge mac_clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [7:0] payload[$];
    int   req_cyc = 0;
    int   earliest = 0;
    bit   earliest_exact = 1'b0;
    bit   abort_flag = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        checks++;
        if (actual < minimum) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected at least %0d", name, actual, minimum);
        end
    endtask

    // Bit-serial reference CRC: one shift per data bit, LSB first.
    function automatic logic [31:0] crcUpdate(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Build the whole expected GMII byte stream for the frame held in payload.
    task automatic pushExpected(input bit golden);
        logic [7:0]  body[$];
        logic [31:0] c;
        logic [31:0] fcs;
        body = payload;
        if (PAD_EN) begin
            while (body.size() < MIN_LEN) body.push_back(8'h00);
        end
        for (int i = 0; i < 7; i++) exp_q.push_back({PREAMBLE_BYTE, 1'b0});
        exp_q.push_back({SFD_BYTE, 1'b0});
        c = CRC_INIT;
        foreach (body[i]) begin
            exp_q.push_back({body[i], 1'b0});
            c = crcUpdate(c, body[i]);
        end
        fcs = (golden && !PAD_EN) ? 32'hCBF43926 : ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back({fcs[8*i +: 8], (i == 3)});
    endtask

    task automatic fillRandom(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge mac_clk);
            #1;
        end
    endtask

    // Called and returns at one time unit after a rising edge.
    task automatic applyStimulus(input int abort_at, input bit golden);
        int n;
        bit acked;
        n = payload.size();
        acked = 1'b0;
        pushExpected(golden);
        req_cyc  = cyc;
        mac_txdv = 1'b1;
        mac_txd  = (n > 0) ? payload[0] : 8'h00;
        for (int i = 0; i < 200; i++) begin
            @(posedge mac_clk);
            #1;
            if (mac_txack) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            mac_txdv = 1'b0;
            exp_q.delete();
            return;
        end
        if (n == 0) mac_txdv = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (abort_at >= 0 && k == abort_at + 1) begin
                reset    = 1'b1;
                mac_txdv = 1'b0;
                mac_txd  = 8'h00;
                @(posedge mac_clk);
                #1;
                reset          = 1'b0;
                exp_q.delete();
                abort_flag     = 1'b1;
                earliest       = cyc + IFG + 1;
                earliest_exact = 1'b0;
                @(negedge mac_clk);
                checkOutput("reset_midframe_outputs",
                            {mac_txack, gmii_txd, gmii_tx_en, gmii_tx_er, frame_sent}, 32'd0);
                @(posedge mac_clk);
                #1;
                abort_flag = 1'b0;
                return;
            end
            mac_txd = payload[k];
            @(posedge mac_clk);
            #1;
        end
        mac_txdv = 1'b0;
        mac_txd  = 8'h00;
        @(posedge mac_clk);
        #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
            @(posedge mac_clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        idleCycles(20);
    endtask

    // Monitor: pops the scoreboard whenever the DUT transmits and checks frame timing.
    initial begin
        exp_t        e;
        bit          prev_en;
        bit          sent_due;
        bit          last_seen;
        int          idx;
        int          pre_start;
        int          exp_start;
        logic [31:0] rx_crc;
        prev_en   = 1'b0;
        sent_due  = 1'b0;
        last_seen = 1'b0;
        idx       = 0;
        pre_start = 0;
        rx_crc    = CRC_INIT;
        forever begin
            @(negedge mac_clk);
            if (frame_sent || sent_due) checkOutput("frame_sent", frame_sent, sent_due);
            sent_due = 1'b0;
            if (mac_txack) checkOutput("ack_cycle", cyc - pre_start, 32'd7);
            if (gmii_tx_en) begin
                if (!prev_en) begin
                    pre_start = cyc;
                    idx       = 0;
                    last_seen = 1'b0;
                    rx_crc    = CRC_INIT;
                    exp_start = (req_cyc + 1 > earliest) ? req_cyc + 1 : earliest;
                    if (earliest_exact) checkOutput("preamble_start", cyc, exp_start);
                    else checkAtLeast("preamble_not_early", cyc, exp_start);
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", {24'h0, gmii_txd}, 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("gmii_byte", {gmii_tx_er, gmii_txd}, {1'b0, e.data});
                    if (idx >= 8) rx_crc = crcUpdate(rx_crc, gmii_txd);
                    idx++;
                    if (e.last) begin
                        sent_due       = 1'b1;
                        last_seen      = 1'b1;
                        earliest       = cyc + IFG + 1;
                        earliest_exact = 1'b1;
                        checkOutput("fcs_residue", rx_crc, CRC_RESIDUE);
                    end
                end
            end else if (prev_en && !abort_flag) begin
                checkOutput("frame_end", last_seen, 32'd1);
            end
            prev_en = gmii_tx_en;
        end
    end

    initial begin
        reset    = 1'b1;
        mac_txdv = 1'b0;
        repeat (3) @(posedge mac_clk);
        @(negedge mac_clk);
        checkOutput("reset_values", {mac_txack, gmii_txd, gmii_tx_en, gmii_tx_er, frame_sent}, 32'd0);
        @(posedge mac_clk);
        #1;
        reset          = 1'b0;
        earliest       = cyc + IFG + 1;
        earliest_exact = 1'b0;

        $display("[TB] frame 123456789");
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'(8'h31 + i));
        applyStimulus(-1, 1'b1);
        waitDrain();

        $display("[TB] short 14-byte payload");
        fillRandom(14);
        applyStimulus(-1, 1'b0);
        waitDrain();

        $display("[TB] zero-length payload");
        payload.delete();
        applyStimulus(-1, 1'b0);
        waitDrain();

        $display("[TB] back-to-back frames");
        fillRandom(20);
        applyStimulus(-1, 1'b0);
        fillRandom(70);
        applyStimulus(-1, 1'b0);
        waitDrain();

        $display("[TB] 1514-byte payload");
        fillRandom(1514);
        applyStimulus(-1, 1'b0);
        waitDrain();

        $display("[TB] reset during payload byte 20");
        fillRandom(40);
        applyStimulus(20, 1'b0);
        fillRandom(30);
        applyStimulus(-1, 1'b0);
        waitDrain();

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            fillRandom($urandom_range(0, 100));
            applyStimulus(-1, 1'b0);
            idleCycles($urandom_range(0, 15));
        end
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
